// File: rtl/button_conditioner.sv
// Two-channel pushbutton conditioner: synchronize, debounce, and emit press strobes plus held levels.
// Define BTN_AUTOREPEAT_EN to add auto-repeat strobes on the Run channel while it is held.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Run_n,
    input  logic Clear_n,
    output logic Run_Pulse,
    output logic Clear_Pulse,
    output logic Run_Held,
    output logic Clear_Held
);

    localparam int MAX_AB    = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_PARAM = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
    localparam int CW        = $clog2(MAX_PARAM) + 1;

    localparam logic [CW-1:0] DB_TERM = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic [1:0] btn_n;
    logic [1:0] pulse_vec;
    logic [1:0] held_vec;

    // Channel 0 is Run, channel 1 is Clear.
    assign btn_n       = {Clear_n, Run_n};
    assign Run_Pulse   = pulse_vec[0];
    assign Clear_Pulse = pulse_vec[1];
    assign Run_Held    = held_vec[0];
    assign Clear_Held  = held_vec[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic          sync1_reg;
            logic          sync2_reg;
            logic          pressed;
            state_t        state_reg;
            state_t        state_next;
            logic [CW-1:0] cnt_reg;
            logic [CW-1:0] cnt_next;
            logic [CW-1:0] cnt_inc;
            logic          pulse_reg;
            logic          pulse_next;
            logic          held_reg;
            logic          held_next;
            logic          accept;
            logic          repeat_fire;

            // Synchronizer idles at 1 so a reset looks like a released button.
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    sync1_reg <= 1'b1;
                    sync2_reg <= 1'b1;
                end else begin
                    sync1_reg <= btn_n[gi];
                    sync2_reg <= sync1_reg;
                end
            end

            assign pressed = ~sync2_reg;
            assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;

            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                accept     = 1'b0;
                case (state_reg)
                    IDLE: begin
                        if (pressed) begin
                            state_next = PRESS_WAIT;
                            cnt_next   = '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!pressed) begin
                            state_next = IDLE;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_inc;
                            if (cnt_inc >= DB_TERM) begin
                                state_next = HELD;
                                accept     = 1'b1;
                            end
                        end
                    end
                    HELD: begin
                        if (!pressed) begin
                            state_next = RELEASE_WAIT;
                            cnt_next   = '0;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (pressed) begin
                            state_next = HELD;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_inc;
                            if (cnt_inc >= DB_TERM) begin
                                state_next = IDLE;
                                cnt_next   = '0;
                            end
                        end
                    end
                    default: begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                endcase
            end

            assign pulse_next = accept | repeat_fire;
            assign held_next  = (state_next == HELD) || (state_next == RELEASE_WAIT);

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    pulse_reg <= 1'b0;
                    held_reg  <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    pulse_reg <= pulse_next;
                    held_reg  <= held_next;
                end
            end

            assign pulse_vec[gi] = pulse_reg;
            assign held_vec[gi]  = held_reg;

`ifdef BTN_AUTOREPEAT_EN
            if (gi == 0) begin : g_repeat
                localparam logic [CW-1:0] DELAY_TERM  = CW'(REPEAT_DELAY - 1);
                localparam logic [CW-1:0] PERIOD_TERM = CW'(REPEAT_PERIOD - 1);

                logic [CW-1:0] rep_cnt_reg;
                logic          rep_first_reg;
                logic          rep_run;

                // Timer only advances while staying in HELD; release debounce freezes it.
                assign rep_run     = (state_reg == HELD) && (state_next == HELD);
                assign repeat_fire = rep_run &&
                                     (rep_cnt_reg == (rep_first_reg ? DELAY_TERM : PERIOD_TERM));

                always_ff @(posedge Clk) begin
                    if (Reset) begin
                        rep_cnt_reg   <= '0;
                        rep_first_reg <= 1'b1;
                    end else if (accept) begin
                        rep_cnt_reg   <= '0;
                        rep_first_reg <= 1'b1;
                    end else if (repeat_fire) begin
                        rep_cnt_reg   <= '0;
                        rep_first_reg <= 1'b0;
                    end else if (rep_run && (rep_cnt_reg != CNT_MAX)) begin
                        rep_cnt_reg <= rep_cnt_reg + 1'b1;
                    end
                end
            end else begin : g_no_repeat
                assign repeat_fire = 1'b0;
            end
`else
            assign repeat_fire = 1'b0;
`endif
        end
    endgenerate

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning the number of consecutive stable synchronized samples needed to accept a press or release (minimum 2).
REQ-002 SHALL have parameter REPEAT_DELAY, default 25000000, meaning the cycles held before the first auto-repeat pulse.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 5000000, meaning the cycles between later auto-repeat pulses.
REQ-004 SHALL have port Clk, input, 1 bit: the single system clock; all logic is rising-edge.
REQ-005 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port Run_n, input, 1 bit: raw active-low Run/Accumulate pushbutton, asynchronous to Clk.
REQ-007 SHALL have port Clear_n, input, 1 bit: raw active-low Reset/Clear pushbutton, asynchronous to Clk.
REQ-008 SHALL have port Run_Pulse, output, 1 bit: single-cycle high strobe per accepted Run press (the register-load strobe for the accumulator).
REQ-009 SHALL have port Clear_Pulse, output, 1 bit: single-cycle high strobe per accepted Clear press.
REQ-010 SHALL have port Run_Held, output, 1 bit: debounced active-high Run level.
REQ-011 SHALL have port Clear_Held, output, 1 bit: debounced active-high Clear level (the accumulator clear level).

Function
REQ-012 SHALL pass each button through its own two-flop synchronizer before any other logic, and SHALL derive no output from an unsynchronized input.
REQ-013 SHALL run one independent FSM per channel with states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT, plus a counter of width clog2(max parameter)+1.
REQ-014 IDLE: a synchronized-pressed sample SHALL move the FSM to PRESS_WAIT and clear the counter.
REQ-015 PRESS_WAIT: each pressed sample SHALL increment the counter; at count DEBOUNCE_CYCLES-1 the FSM SHALL enter HELD and assert the channel Pulse for exactly that one cycle; any released sample SHALL return the FSM to IDLE with no pulse.
REQ-016 HELD: a released sample SHALL move the FSM to RELEASE_WAIT and clear the counter; Held SHALL be 1 in both HELD and RELEASE_WAIT.
REQ-017 RELEASE_WAIT: DEBOUNCE_CYCLES consecutive released samples SHALL move the FSM to IDLE (Held to 0); any pressed sample SHALL return it to HELD with no new pulse.
REQ-018 Latency: with stable input, Pulse SHALL rise on the (DEBOUNCE_CYCLES+2)th rising edge after the first edge that samples the input low; Held SHALL rise on the same edge.
REQ-019 Channels SHALL be fully independent; simultaneous presses SHALL give both pulses in the same cycle, with no priority between channels.
REQ-020 A press held indefinitely SHALL produce exactly one pulse, except as in REQ-025; counters SHALL saturate and never wrap.

Reset
REQ-021 While Reset=1 at a rising edge, all four outputs SHALL be 0 on the next cycle, both FSMs SHALL go to IDLE, counters SHALL be 0, and synchronizer flops SHALL be 1 (released).
REQ-022 Reset asserted mid-debounce or mid-hold SHALL abort with no pulse; if a button is still pressed after Reset drops, it SHALL be treated as a new press and debounced from IDLE.
REQ-023 The Clear button SHALL have no internal effect on this block; it only produces outputs.

Configuration
REQ-024 Macro BTN_AUTOREPEAT_EN SHALL control Run-channel auto-repeat.
REQ-025 With BTN_AUTOREPEAT_EN defined, Run in HELD SHALL emit extra single-cycle Run_Pulse strobes REPEAT_DELAY cycles after entering HELD and every REPEAT_PERIOD cycles after that; RELEASE_WAIT SHALL stop the repeat timer, and returning to HELD from RELEASE_WAIT SHALL resume it without resetting it.
REQ-026 Without BTN_AUTOREPEAT_EN, no repeat logic SHALL be synthesized and REQ-020 SHALL hold strictly; the Clear channel SHALL never auto-repeat in either build.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-027 Run_n driven low and held from cycle 0 -> Run_Pulse high only in cycle 6 and Run_Held high from cycle 6; with the macro off, no further pulse over 100 cycles.
REQ-028 Run_n bounces low 2, high 1, low 2, high 1 and then stays high -> no Run_Pulse; Run_Held stays 0.
REQ-029 Run_n and Clear_n both driven low in the same cycle and held -> Run_Pulse and Clear_Pulse both high in the same single cycle.
REQ-030 Run_n pressed and accepted, then released with one 2-cycle low glitch during release debounce -> Run_Held stays 1 through the glitch, falls after 4 clean high samples, and no second pulse occurs.
REQ-031 Reset asserted in PRESS_WAIT at count 2 while Run_n stays low, then released -> no pulse during reset, then one Run_Pulse 6 cycles after Reset drops.
REQ-032 With BTN_AUTOREPEAT_EN defined, Run_n held 60 cycles -> Run_Pulse at entry to HELD, then at +20, +28, +36, +44 and +52 cycles after that entry.
